// File: rtl/lane_serialiser.sv
// Serialises the active lanes of a SIMT vector op onto a single shared-unit
// request port and writes the in-order responses back to the register file.
module lane_serialiser #(
   parameter int LANES   = 4,
   parameter int DW      = 32,
   parameter int OPW     = 3,
   parameter int DESTW   = 6,
   parameter int MAX_OUT = 2,
   localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  op_valid_i,
   output logic                  op_ready_o,
   input  logic [LANES-1:0]      op_mask_i,
   input  logic [OPW-1:0]        op_code_i,
   input  logic [DESTW-1:0]      op_dest_i,
   input  logic [LANES*DW-1:0]   op_a_i,
   input  logic [LANES*DW-1:0]   op_b_i,
   output logic                  req_valid_o,
   input  logic                  req_ready_i,
   output logic [DW-1:0]         req_a_o,
   output logic [DW-1:0]         req_b_o,
   output logic [OPW-1:0]        req_op_o,
   output logic [LW-1:0]         req_lane_o,
   input  logic                  rsp_valid_i,
   input  logic [DW-1:0]         rsp_data_i,
   output logic                  wb_valid_o,
   output logic [LW-1:0]         wb_lane_o,
   output logic [DESTW-1:0]      wb_dest_o,
   output logic [DW-1:0]         wb_data_o,
   output logic                  done_o,
   output logic                  busy_o,
   output logic                  err_o
);

   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t               r_state, w_state_nxt;
   logic [LANES-1:0]     r_pending;
   logic [OPW-1:0]       r_code;
   logic [DESTW-1:0]     r_dest;
   logic [LANES*DW-1:0]  r_a, r_b;
   logic [OW-1:0]        r_out;
   logic [LW-1:0]        r_fifo [MAX_OUT];
   logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
   logic                 r_wb_valid;
   logic [LW-1:0]        r_wb_lane;
   logic [DESTW-1:0]     r_wb_dest;
   logic [DW-1:0]        r_wb_data;
   logic                 r_done, r_err;

   logic                 w_accept, w_issue, w_rsp_ok, w_last_rsp;
   logic [LW-1:0]        w_lane;
   logic [LANES-1:0]     w_pending_nxt;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   // Lowest-indexed lane still waiting to issue.
   always_comb begin
      w_lane = '0;
      for (int i = LANES - 1; i >= 0; i--)
         if (r_pending[i]) w_lane = LW'(i);
   end

   assign w_pending_nxt = r_pending & ~(LANES'(1) << w_lane);

   assign op_ready_o  = (r_state == IDLE) && !rst_i;
   assign busy_o      = (r_state != IDLE);
   assign w_accept    = op_valid_i && op_ready_o;
   assign req_valid_o = (r_state == ISSUE) && (r_out != OW'(MAX_OUT));
   assign w_issue     = req_valid_o && req_ready_i;
   assign w_rsp_ok    = rsp_valid_i && (r_out != '0);
   assign w_last_rsp  = w_rsp_ok && (r_state == DRAIN) && (r_out == OW'(1));

   assign req_a_o    = r_a[int'(w_lane)*DW +: DW];
   assign req_b_o    = r_b[int'(w_lane)*DW +: DW];
   assign req_op_o   = r_code;
   assign req_lane_o = w_lane;

   assign wb_valid_o = r_wb_valid;
   assign wb_lane_o  = r_wb_lane;
   assign wb_dest_o  = r_wb_dest;
   assign wb_data_o  = r_wb_data;
   assign done_o     = r_done;
   assign err_o      = r_err;

   // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_accept && (op_mask_i != '0)) w_state_nxt = ISSUE;
         ISSUE:   if (w_issue && (w_pending_nxt == '0)) w_state_nxt = DRAIN;
         DRAIN:   if (w_last_rsp) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_pending  <= '0;
         r_code     <= '0;
         r_dest     <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_out      <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_wb_valid <= 1'b0;
         r_wb_lane  <= '0;
         r_wb_dest  <= '0;
         r_wb_data  <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_pending <= op_mask_i;
            r_code    <= op_code_i;
            r_dest    <= op_dest_i;
            r_a       <= op_a_i;
            r_b       <= op_b_i;
         end else if (w_issue) begin
            r_pending <= w_pending_nxt;
         end
         if (w_issue && !w_rsp_ok)      r_out <= r_out + 1'b1;
         else if (!w_issue && w_rsp_ok) r_out <= r_out - 1'b1;
         if (w_issue)  r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_rsp_ok) r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_wb_valid <= w_rsp_ok;
         if (w_rsp_ok) begin
            r_wb_lane <= r_fifo[r_rd_ptr];
            r_wb_dest <= r_dest;
            r_wb_data <= rsp_data_i;
         end
         r_done <= w_last_rsp || (w_accept && (op_mask_i == '0));
         if (rsp_valid_i && (r_out == '0)) r_err <= 1'b1;
      end
   end

   // NOTE: tag storage needs no reset; the pointers and outstanding count define what is valid.
   always_ff @(posedge clk_i) begin
      if (w_issue) r_fifo[r_wr_ptr] <= w_lane;
   end

endmodule

// File: tb/tb_lane_serialiser.sv
// Self-checking bench: randomized operands/responses against a transaction-level
// model of lane ordering, in-flight limit, in-order writeback and completion.
module tb_lane_serialiser;

   localparam int LANES   = 4;
   localparam int DW      = 32;
   localparam int OPW     = 3;
   localparam int DESTW   = 6;
   localparam int MAX_OUT = 2;
   localparam int LW      = 2;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic                 op_valid_i;
   logic                 op_ready_o;
   logic [LANES-1:0]     op_mask_i;
   logic [OPW-1:0]       op_code_i;
   logic [DESTW-1:0]     op_dest_i;
   logic [LANES*DW-1:0]  op_a_i, op_b_i;
   logic                 req_valid_o, req_ready_i;
   logic [DW-1:0]        req_a_o, req_b_o;
   logic [OPW-1:0]       req_op_o;
   logic [LW-1:0]        req_lane_o;
   logic                 rsp_valid_i;
   logic [DW-1:0]        rsp_data_i;
   logic                 wb_valid_o;
   logic [LW-1:0]        wb_lane_o;
   logic [DESTW-1:0]     wb_dest_o;
   logic [DW-1:0]        wb_data_o;
   logic                 done_o, busy_o, err_o;

   always #5 clk_i = ~clk_i;

   lane_serialiser #(.LANES(LANES), .DW(DW), .OPW(OPW), .DESTW(DESTW), .MAX_OUT(MAX_OUT)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_mask_i(op_mask_i),
      .op_code_i(op_code_i), .op_dest_i(op_dest_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
      .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_a_o(req_a_o),
      .req_b_o(req_b_o), .req_op_o(req_op_o), .req_lane_o(req_lane_o),
      .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
      .wb_valid_o(wb_valid_o), .wb_lane_o(wb_lane_o), .wb_dest_o(wb_dest_o),
      .wb_data_o(wb_data_o), .done_o(done_o), .busy_o(busy_o), .err_o(err_o)
   );

   typedef struct {int lane; int due;} infl_t;

   int n_checks = 0, n_errors = 0, cyc = 0;

   // Stimulus controls
   bit rst_cmd, op_req, rsp_en, fixed_data, force_rsp;
   int ready_mode, stall_lane, stall_left, rsp_lat;

   // Reference model
   bit             m_busy, m_err, m_done, m_wb;
   int             m_out, op_left, m_wb_lane;
   logic [DW-1:0]  m_wb_data;
   logic [DESTW-1:0] m_dest, m_wb_dest;
   logic [OPW-1:0] m_code;
   logic [DW-1:0]  m_a [LANES];
   logic [DW-1:0]  m_b [LANES];
   int             exp_lanes[$];
   infl_t          infl_q[$];
   int             t_acc, done_lat, wb_count, lane2_issues;
   bit             prev_stall;
   logic [DW-1:0]  prev_a, prev_b;
   logic [OPW-1:0] prev_op;
   logic [LW-1:0]  prev_lane;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic observe();
      chk("busy", busy_o, m_busy);
      chk("op_ready", op_ready_o, !rst_i && !m_busy);
      chk("err", err_o, m_err);
      chk("wb_valid", wb_valid_o, m_wb);
      if (m_wb) begin
         chk("wb_lane", wb_lane_o, m_wb_lane);
         chk("wb_data", wb_data_o, m_wb_data);
         chk("wb_dest", wb_dest_o, m_wb_dest);
         wb_count++;
      end
      chk("done", done_o, m_done);
      if (m_done) done_lat = cyc - t_acc;
      if (exp_lanes.size() == 0) begin
         chk("req_valid_unexpected", req_valid_o, 0);
      end else if (req_valid_o) begin
         chk("req_lane", req_lane_o, exp_lanes[0]);
         chk("req_a", req_a_o, m_a[exp_lanes[0]]);
         chk("req_b", req_b_o, m_b[exp_lanes[0]]);
         chk("req_op", req_op_o, m_code);
         chk("req_within_max_out", m_out < MAX_OUT, 1);
      end
      if (prev_stall) begin
         chk("hold_valid", req_valid_o, 1);
         chk("hold_a", req_a_o, prev_a);
         chk("hold_b", req_b_o, prev_b);
         chk("hold_op", req_op_o, prev_op);
         chk("hold_lane", req_lane_o, prev_lane);
      end
   endtask

   task automatic drive();
      rst_i      = rst_cmd;
      op_valid_i = op_req;
      case (ready_mode)
         0: req_ready_i = 1'b1;
         1: req_ready_i = ($urandom_range(0, 9) < 7);
         default: begin
            if (req_valid_o && (int'(req_lane_o) == stall_lane) && (stall_left > 0)) begin
               req_ready_i = 1'b0;
               stall_left--;
            end else begin
               req_ready_i = 1'b1;
            end
         end
      endcase
      rsp_valid_i = 1'b0;
      rsp_data_i  = '0;
      if (force_rsp) begin
         rsp_valid_i = 1'b1;
         rsp_data_i  = 32'hdead_beef;
         force_rsp   = 1'b0;
      end else if (rsp_en && (infl_q.size() > 0) && (infl_q[0].due <= cyc)) begin
         rsp_valid_i = 1'b1;
         rsp_data_i  = fixed_data ? DW'(32'h10 + infl_q[0].lane) : DW'($urandom);
      end
   endtask

   task automatic predict();
      bit    issue, rsp_ok;
      infl_t f;
      m_wb       = 1'b0;
      m_done     = 1'b0;
      prev_stall = !rst_i && req_valid_o && !req_ready_i;
      prev_a = req_a_o; prev_b = req_b_o; prev_op = req_op_o; prev_lane = req_lane_o;
      if (rst_i) begin
         m_busy = 1'b0; m_err = 1'b0; m_out = 0; op_left = 0;
         exp_lanes.delete(); infl_q.delete();
      end else begin
         issue  = req_valid_o && req_ready_i;
         rsp_ok = rsp_valid_i && (m_out > 0);
         if (rsp_valid_i && (m_out == 0)) m_err = 1'b1;
         if (rsp_ok && (infl_q.size() > 0)) begin
            f = infl_q.pop_front();
            m_wb = 1'b1; m_wb_lane = f.lane; m_wb_data = rsp_data_i; m_wb_dest = m_dest;
            op_left--;
            if (op_left == 0) begin
               m_done = 1'b1;
               m_busy = 1'b0;
            end
         end
         if (issue && (exp_lanes.size() > 0)) begin
            f.lane = exp_lanes.pop_front();
            f.due  = cyc + rsp_lat;
            infl_q.push_back(f);
            if (f.lane == 2) lane2_issues++;
         end
         m_out = m_out + int'(issue) - int'(rsp_ok);
         if (op_valid_i && op_ready_o) begin
            op_req = 1'b0; t_acc = cyc; wb_count = 0;
            if (op_mask_i == '0) begin
               m_done = 1'b1;
            end else begin
               m_busy = 1'b1; op_left = $countones(op_mask_i);
               m_code = op_code_i; m_dest = op_dest_i;
               exp_lanes.delete();
               for (int i = 0; i < LANES; i++) begin
                  m_a[i] = op_a_i[i*DW +: DW];
                  m_b[i] = op_b_i[i*DW +: DW];
                  if (op_mask_i[i]) exp_lanes.push_back(i);
               end
            end
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk_i);
      observe();
      drive();
      #1;
      predict();
      cyc++;
   endtask

   task automatic load_op(input logic [LANES-1:0] mask);
      for (int i = 0; i < LANES; i++) begin
         op_a_i[i*DW +: DW] = $urandom;
         op_b_i[i*DW +: DW] = $urandom;
      end
      op_mask_i = mask;
      op_code_i = OPW'($urandom);
      op_dest_i = DESTW'($urandom);
      op_req    = 1'b1;
   endtask

   task automatic run_op(input logic [LANES-1:0] mask, input int lat);
      int k;
      rsp_lat = lat;
      load_op(mask);
      k = 0;
      do begin
         cycle();
         k++;
      end while ((k < 500) && (op_req || m_busy || m_wb || m_done));
      chk("op_completes_in_budget", k < 500, 1);
   endtask

   initial begin
      rst_cmd = 1'b1; rst_i = 1'b1; op_valid_i = 1'b0; op_mask_i = '0; op_code_i = '0;
      op_dest_i = '0; op_a_i = '0; op_b_i = '0; req_ready_i = 1'b1;
      rsp_valid_i = 1'b0; rsp_data_i = '0;
      op_req = 1'b0; rsp_en = 1'b1; fixed_data = 1'b0; force_rsp = 1'b0;
      ready_mode = 0; stall_lane = 2; stall_left = 0; rsp_lat = 1;

      // Reset: outputs quiet, op_ready low while reset is held
      repeat (3) cycle();
      chk("rst_req_a", req_a_o, 0);
      chk("rst_req_op", req_op_o, 0);
      chk("rst_req_lane", req_lane_o, 0);
      chk("rst_wb_data", wb_data_o, 0);
      chk("rst_wb_dest", wb_dest_o, 0);
      rst_cmd = 1'b0;
      repeat (2) cycle();
      chk("post_rst_ready", op_ready_o, 1);

      // Full mask, fixed response data 0x10+lane, 3-cycle response latency
      fixed_data = 1'b1;
      run_op(4'b1111, 3);
      chk("full_mask_wb_count", wb_count, 4);

      // Sparse mask: lanes 1 and 3 only
      run_op(4'b1010, 3);
      chk("sparse_mask_wb_count", wb_count, 2);

      // Empty mask: done one cycle after accept, no requests, never busy
      run_op(4'b0000, 3);
      chk("zero_mask_wb_count", wb_count, 0);
      chk("zero_mask_done_latency", done_lat, 1);

      // Backpressure on lane 2 for five cycles
      fixed_data = 1'b0; ready_mode = 2; stall_left = 5; lane2_issues = 0;
      run_op(4'b1111, 2);
      chk("stall_cycles_consumed", stall_left, 0);
      chk("lane2_issued_once", lane2_issues, 1);
      chk("stall_wb_count", wb_count, 4);

      // One-cycle responses: issue and response coincide, no throttling
      ready_mode = 0;
      run_op(4'b1111, 1);
      chk("overlap_wb_count", wb_count, 4);
      chk("overlap_done_latency", done_lat, 6);

      // Reset during DRAIN with one outstanding, then a late response
      rsp_en = 1'b0;
      load_op(4'b0001);
      repeat (4) cycle();
      chk("drain_before_reset", busy_o && !req_valid_o, 1);
      rst_cmd = 1'b1;
      repeat (2) cycle();
      rst_cmd = 1'b0;
      cycle();
      force_rsp = 1'b1;
      repeat (2) cycle();
      chk("late_rsp_err", err_o, 1);
      chk("late_rsp_no_wb", wb_valid_o, 0);
      chk("late_rsp_ready", op_ready_o, 1);
      repeat (3) cycle();
      rsp_en = 1'b1; rst_cmd = 1'b1;
      cycle();
      rst_cmd = 1'b0;
      repeat (2) cycle();

      // Randomized ops: masks, operands, latency, backpressure, response data
      for (int n = 0; n < 30; n++) begin
         logic [LANES-1:0] mask;
         mask = ($urandom_range(0, 7) == 0) ? '0 : LANES'($urandom);
         ready_mode = $urandom_range(0, 1);
         run_op(mask, $urandom_range(1, 4));
         chk("random_wb_count", wb_count, $countones(mask));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
